// File: rtl/vp_pkg.sv
// ---------------------------------------------------------------------------
// vp_pkg
// Shared definitions for the DVP black-fill frame controller.
//   vp_state_e : controller FSM encoding (IDLE, ACQUIRE, MEASURE, LOCKED)
//   VP_CW      : width of every geometry counter
//   VP_SAT_MAX : saturation ceiling for those counters
// ---------------------------------------------------------------------------
package vp_pkg;

  localparam int VP_CW = 12;
  localparam logic [VP_CW-1:0] VP_SAT_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } vp_state_e;

endpackage

// File: rtl/vp_geom_meas.sv
// ---------------------------------------------------------------------------
// vp_geom_meas
// Measures active width/height of each frame on the pre_vs/pre_de stream.
//
// Ports:
//   clk, rst      : pixel clock, synchronous active-high reset
//   pre_vs, pre_de: video sync / data enable
//   commit_en     : allows the measured geometry to be latched at vs rise
//   commit        : vs rising edge this cycle (frame boundary strobe)
//   width, height : geometry of the frame closing this cycle (valid with commit)
//   consistent    : closing frame has equal min/max line length and >0 lines
//   meas_width    : last committed width
//   meas_height   : last committed height
// ---------------------------------------------------------------------------
module vp_geom_meas
  import vp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_vs,
  input  logic             pre_de,
  input  logic             commit_en,
  output logic             commit,
  output logic [VP_CW-1:0] width,
  output logic [VP_CW-1:0] height,
  output logic             consistent,
  output logic [VP_CW-1:0] meas_width,
  output logic [VP_CW-1:0] meas_height
);

  function automatic logic [VP_CW-1:0] sat_inc(input logic [VP_CW-1:0] v);
    return (v == VP_SAT_MAX) ? v : v + 1'b1;
  endfunction

  logic             vs_d, de_d;
  logic             vs_rise, de_fall, line_done;
  logic [VP_CW-1:0] line_cnt, frame_min, frame_max, height_cnt;
  logic [VP_CW-1:0] min_nx, max_nx, height_nx;

  assign vs_rise = pre_vs & ~vs_d;
  assign de_fall = ~pre_de & de_d;
  // A line only ends if its last pixel was outside vsync; this still lets a
  // line ending exactly on the vs rise close into the outgoing frame.
  assign line_done = de_fall & ~vs_d;

  // Running min/max/height including a line that ends this very cycle, so
  // the frame commit sees it even when it coincides with vs rise.
  always_comb begin
    min_nx    = frame_min;
    max_nx    = frame_max;
    height_nx = height_cnt;
    if (line_done) begin
      height_nx = sat_inc(height_cnt);
      if (height_cnt == '0) begin
        min_nx = line_cnt;
        max_nx = line_cnt;
      end else begin
        if (line_cnt < frame_min) min_nx = line_cnt;
        if (line_cnt > frame_max) max_nx = line_cnt;
      end
    end
  end

  assign commit     = vs_rise;
  assign width      = max_nx;
  assign height     = height_nx;
  assign consistent = (min_nx == max_nx) && (height_nx != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      line_cnt    <= '0;
      frame_min   <= '0;
      frame_max   <= '0;
      height_cnt  <= '0;
      meas_width  <= '0;
      meas_height <= '0;
    end else begin
      vs_d <= pre_vs;
      de_d <= pre_de;
      if (vs_rise) begin
        line_cnt   <= '0;
        frame_min  <= '0;
        frame_max  <= '0;
        height_cnt <= '0;
        if (commit_en) begin
          meas_width  <= max_nx;
          meas_height <= height_nx;
        end
      end else begin
        frame_min  <= min_nx;
        frame_max  <= max_nx;
        height_cnt <= height_nx;
        if (line_done)
          line_cnt <= '0;
        else if (pre_de && !pre_vs)
          line_cnt <= sat_inc(line_cnt);
      end
    end
  end

endmodule

// File: rtl/vp_frame_ctrl.sv
// ---------------------------------------------------------------------------
// vp_frame_ctrl
// Per-frame controller for the horizontal black-fill stage. Measures frame
// geometry, locks once it is stable, and toggles the filler enable only at
// frame boundaries.
//
// Parameters: H_DISP (target line width), V_DISP (target line count),
//             LOCK_FRAMES (stable frames needed to lock, 1..15)
// Ports:
//   clk, rst      : pixel clock, synchronous active-high reset
//   ctrl_en       : software enable, low forces IDLE
//   pre_vs, pre_de: video stream shared with the filler
//   filler_en     : filler EN
//   locked        : geometry locked
//   meas_width    : committed width of last frame
//   meas_height   : committed height of last frame
//   width_short   : locked and width below H_DISP
//   height_short  : locked and height below V_DISP
//   unlock_cnt    : saturating count of lock losses due to geometry
//   irq_clr, irq  : sticky lock-change interrupt, only when
//                   VP_FRAME_CTRL_IRQ_EN is defined
// ---------------------------------------------------------------------------
module vp_frame_ctrl
  import vp_pkg::*;
#(
  parameter logic [11:0] H_DISP      = 12'd1280,
  parameter logic [11:0] V_DISP      = 12'd720,
  parameter int          LOCK_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_en,
  input  logic             pre_vs,
  input  logic             pre_de,
  output logic             filler_en,
  output logic             locked,
  output logic [VP_CW-1:0] meas_width,
  output logic [VP_CW-1:0] meas_height,
  output logic             width_short,
  output logic             height_short,
  output logic [7:0]       unlock_cnt
`ifdef VP_FRAME_CTRL_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 1'b1;
  endfunction

  vp_state_e        state, next_state;
  logic [3:0]       stable_cnt, stable_nx;
  logic             unlock_inc;
  logic             commit, consistent, commit_en, same_geom;
  logic [VP_CW-1:0] g_width, g_height;

  // Only frames measured after the discarded ACQUIRE frame update readback.
  assign commit_en = ctrl_en && (state == MEASURE || state == LOCKED);

  vp_geom_meas u_geom (
    .clk         (clk),
    .rst         (rst),
    .pre_vs      (pre_vs),
    .pre_de      (pre_de),
    .commit_en   (commit_en),
    .commit      (commit),
    .width       (g_width),
    .height      (g_height),
    .consistent  (consistent),
    .meas_width  (meas_width),
    .meas_height (meas_height)
  );

  assign same_geom = (g_width == meas_width) && (g_height == meas_height);

  always_comb begin
    next_state = state;
    stable_nx  = stable_cnt;
    unlock_inc = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en) next_state = ACQUIRE;
      end
      ACQUIRE: begin
        if (commit) begin
          next_state = MEASURE;
          stable_nx  = '0;
        end
      end
      MEASURE: begin
        if (commit) begin
          if (consistent && same_geom) stable_nx = sat_inc4(stable_cnt);
          else if (consistent)         stable_nx = 4'd1;
          else                         stable_nx = '0;
          if (int'(stable_nx) >= LOCK_FRAMES) next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (commit && (!consistent || !same_geom)) begin
          next_state = MEASURE;
          stable_nx  = '0;
          unlock_inc = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (!ctrl_en) begin
      next_state = IDLE;
      stable_nx  = '0;
      unlock_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stable_cnt <= '0;
      unlock_cnt <= '0;
      locked     <= 1'b0;
      filler_en  <= 1'b0;
    end else begin
      state      <= next_state;
      stable_cnt <= stable_nx;
      locked     <= (next_state == LOCKED);
      if (unlock_inc) unlock_cnt <= sat_inc8(unlock_cnt);
      // Filler EN moves only at a frame boundary, or drops on disable.
      if (!ctrl_en)
        filler_en <= 1'b0;
      else if (commit)
        filler_en <= (next_state == LOCKED) && (g_width < H_DISP);
    end
  end

  assign width_short  = locked && (meas_width < H_DISP);
  assign height_short = locked && (meas_height < V_DISP);

`ifdef VP_FRAME_CTRL_IRQ_EN
  logic lock_change;
  assign lock_change = (state == LOCKED) != (next_state == LOCKED);

  // Set has priority over clear so a change is never lost.
  always_ff @(posedge clk) begin
    if (rst)              irq <= 1'b0;
    else if (lock_change) irq <= 1'b1;
    else if (irq_clr)     irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_vp_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vp_frame_ctrl
// Directed bench for vp_frame_ctrl with H_DISP=16, V_DISP=4, LOCK_FRAMES=2.
// A table of frames (geometry plus expected outputs after the closing vs
// rise) drives the main flow; hand sequences cover disable, reset and irq.
// ---------------------------------------------------------------------------
module tb_vp_frame_ctrl;

  logic        clk;
  logic        rst, ctrl_en, pre_vs, pre_de;
  logic        filler_en, locked, width_short, height_short;
  logic [11:0] meas_width, meas_height;
  logic [7:0]  unlock_cnt;
`ifdef VP_FRAME_CTRL_IRQ_EN
  logic        irq_clr, irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vp_frame_ctrl #(
    .H_DISP      (12'd16),
    .V_DISP      (12'd4),
    .LOCK_FRAMES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_en      (ctrl_en),
    .pre_vs       (pre_vs),
    .pre_de       (pre_de),
    .filler_en    (filler_en),
    .locked       (locked),
    .meas_width   (meas_width),
    .meas_height  (meas_height),
    .width_short  (width_short),
    .height_short (height_short),
    .unlock_cnt   (unlock_cnt)
`ifdef VP_FRAME_CTRL_IRQ_EN
    ,
    .irq_clr      (irq_clr),
    .irq          (irq)
`endif
  );

  typedef struct {
    int nl;        // lines in frame
    int w;         // pixels per line
    int bad_w;     // if nonzero, width of line index 1
    int last_gap;  // blanking after last line (0 = de falls on vs rise)
    bit e_lock;
    bit e_fen;
    bit e_ws;
    bit e_hs;
    int e_w;
    int e_h;
    int e_unl;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int w, input int gap);
    pre_de = 1'b1;
    repeat (w) step();
    pre_de = 1'b0;
    repeat (gap) step();
  endtask

  task automatic frame_body(input int nl, input int w, input int bad_w, input int last_gap);
    for (int i = 0; i < nl; i++) begin
      line((i == 1 && bad_w != 0) ? bad_w : w, (i == nl - 1) ? last_gap : 3);
    end
  endtask

  task automatic vsync();
    pre_de = 1'b0;
    pre_vs = 1'b1;
    step();
  endtask

  task automatic vs_tail();
    step();
    pre_vs = 1'b0;
    step();
    step();
  endtask

  task automatic chk_all(input string tag, input bit e_lock, input bit e_fen,
                         input bit e_ws, input bit e_hs, input int e_w,
                         input int e_h, input int e_unl);
    chk({tag, ".locked"},       int'(locked),       int'(e_lock));
    chk({tag, ".filler_en"},    int'(filler_en),    int'(e_fen));
    chk({tag, ".width_short"},  int'(width_short),  int'(e_ws));
    chk({tag, ".height_short"}, int'(height_short), int'(e_hs));
    chk({tag, ".meas_width"},   int'(meas_width),   e_w);
    chk({tag, ".meas_height"},  int'(meas_height),  e_h);
    chk({tag, ".unlock_cnt"},   int'(unlock_cnt),   e_unl);
  endtask

  initial begin
    bit prev_fen;

    //            nl  w  bad gap  lk fen ws hs  w   h  unl
    vecs[0]  = '{4, 12, 0,  3,  0, 0,  0, 0, 12, 4, 0};
    vecs[1]  = '{4, 12, 0,  3,  1, 1,  1, 0, 12, 4, 0};
    vecs[2]  = '{4, 12, 0,  3,  1, 1,  1, 0, 12, 4, 0};
    vecs[3]  = '{4, 12, 11, 3,  0, 0,  0, 0, 12, 4, 1};
    vecs[4]  = '{4, 12, 0,  3,  0, 0,  0, 0, 12, 4, 1};
    vecs[5]  = '{4, 12, 0,  3,  1, 1,  1, 0, 12, 4, 1};
    vecs[6]  = '{4, 16, 0,  3,  0, 0,  0, 0, 16, 4, 2};
    vecs[7]  = '{4, 16, 0,  3,  0, 0,  0, 0, 16, 4, 2};
    vecs[8]  = '{4, 16, 0,  3,  1, 0,  0, 0, 16, 4, 2};
    vecs[9]  = '{3, 16, 0,  3,  0, 0,  0, 0, 16, 3, 3};
    vecs[10] = '{3, 16, 0,  3,  0, 0,  0, 0, 16, 3, 3};
    vecs[11] = '{3, 16, 0,  3,  1, 0,  0, 1, 16, 3, 3};
    vecs[12] = '{4, 12, 0,  3,  0, 0,  0, 0, 12, 4, 4};
    vecs[13] = '{4, 12, 0,  0,  0, 0,  0, 0, 12, 4, 4};
    vecs[14] = '{4, 12, 0,  0,  1, 1,  1, 0, 12, 4, 4};

    rst     = 1'b1;
    ctrl_en = 1'b1;
    pre_vs  = 1'b0;
    pre_de  = 1'b0;
`ifdef VP_FRAME_CTRL_IRQ_EN
    irq_clr = 1'b0;
`endif
    step();
    step();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
`ifdef VP_FRAME_CTRL_IRQ_EN
    chk("reset.irq", int'(irq), 0);
`endif
    rst = 1'b0;
    step();

    // Partial frame seen in ACQUIRE is discarded.
    line(12, 3);
    vsync();
    chk_all("acquire", 0, 0, 0, 0, 0, 0, 0);
    vs_tail();

    prev_fen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      frame_body(vecs[i].nl, vecs[i].w, vecs[i].bad_w, vecs[i].last_gap);
      chk($sformatf("vec%0d.fen_hold", i), int'(filler_en), int'(prev_fen));
      vsync();
      chk_all($sformatf("vec%0d", i), vecs[i].e_lock, vecs[i].e_fen, vecs[i].e_ws,
              vecs[i].e_hs, vecs[i].e_w, vecs[i].e_h, vecs[i].e_unl);
      prev_fen = vecs[i].e_fen;
      vs_tail();
    end

    // ctrl_en dropped mid-line while locked.
    pre_de = 1'b1;
    repeat (5) step();
    ctrl_en = 1'b0;
    step();
    chk_all("disable", 0, 0, 0, 0, 12, 4, 4);
    repeat (7) step();
    pre_de = 1'b0;
    repeat (3) step();
    ctrl_en = 1'b1;
    step();
    frame_body(3, 12, 0, 3);
    vsync();
    chk_all("reen_acq", 0, 0, 0, 0, 12, 4, 4);
    vs_tail();
    frame_body(4, 12, 0, 3);
    vsync();
    chk_all("reen_f1", 0, 0, 0, 0, 12, 4, 4);
    vs_tail();
    frame_body(4, 12, 0, 3);
    vsync();
    chk_all("reen_f2", 1, 1, 1, 0, 12, 4, 4);
    vs_tail();

    // Reset pulsed mid-line at pixel 7.
    pre_de = 1'b1;
    repeat (7) step();
    rst = 1'b1;
    step();
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
`ifdef VP_FRAME_CTRL_IRQ_EN
    chk("midrst.irq", int'(irq), 0);
`endif
    rst = 1'b0;
    repeat (5) step();
    pre_de = 1'b0;
    repeat (3) step();
    frame_body(3, 12, 0, 3);
    vsync();
    chk_all("rst_acq", 0, 0, 0, 0, 0, 0, 0);
    vs_tail();
    frame_body(4, 12, 0, 3);
    vsync();
    chk_all("rst_f1", 0, 0, 0, 0, 12, 4, 0);
    vs_tail();
    frame_body(4, 12, 0, 3);
    vsync();
    chk_all("rst_f2", 1, 1, 1, 0, 12, 4, 0);
    vs_tail();

`ifdef VP_FRAME_CTRL_IRQ_EN
    chk("irq.lock_entry", int'(irq), 1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq.cleared", int'(irq), 0);
    frame_body(4, 12, 11, 3);
    vsync();
    chk("irq.break", int'(irq), 1);
    chk("irq.break_locked", int'(locked), 0);
    vs_tail();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq.cleared2", int'(irq), 0);
    frame_body(4, 12, 0, 3);
    vsync();
    vs_tail();
    frame_body(4, 12, 0, 3);
    pre_de  = 1'b0;
    pre_vs  = 1'b1;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq.set_wins", int'(irq), 1);
    chk("irq.relocked", int'(locked), 1);
    vs_tail();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
